// File: rtl/pixel_job_if.sv
// Job bus between the pixel dispatcher and the ray-tracing cores.
// A job transfers on a rising edge where job_valid[i] and core_ready[i] are both high;
// job_valid and the payload stay stable until that transfer happens.
interface pixel_job_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic [3:0]     job_valid;
  logic [X_W-1:0] job_x;
  logic [Y_W-1:0] job_y;
  logic           job_first;
  logic           job_eol;
  logic [3:0]     core_ready;

  modport master (
    output job_valid, job_x, job_y, job_first, job_eol,
    input  core_ready
  );

  modport slave (
    input  job_valid, job_x, job_y, job_first, job_eol,
    output core_ready
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// Walks the frame in raster order and issues one pixel per job to up to four cores,
// in strict round-robin, so pixel k always lands on core (k mod n_active).
module pixel_dispatcher #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int X_W           = 10,
  parameter int Y_W           = 10
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  logic [2:0]    no_of_extra_cores,
  pixel_job_if.master   job,
  output logic          busy,
  output logic          frame_done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

  state_t         state, state_nxt;
  logic [X_W-1:0] x, x_nxt;
  logic [Y_W-1:0] y, y_nxt;
  logic [1:0]     target, target_nxt;
  // Index of the highest active core (n_active - 1), latched at start.
  logic [1:0]     n_last, n_last_nxt;
  logic           handshake;
  logic [1:0]     extra_clamped;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= ST_IDLE;
      x      <= '0;
      y      <= '0;
      target <= '0;
      n_last <= '0;
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      target <= target_nxt;
      n_last <= n_last_nxt;
    end
  end

  always_comb begin
    extra_clamped = (no_of_extra_cores > 3'd3) ? 2'd3 : no_of_extra_cores[1:0];
    handshake     = (state == ST_DISPATCH) && job.core_ready[target];
  end

  always_comb begin
    state_nxt  = state;
    x_nxt      = x;
    y_nxt      = y;
    target_nxt = target;
    n_last_nxt = n_last;
    case (state)
      ST_IDLE: begin
        if (start) begin
          n_last_nxt = extra_clamped;
          x_nxt      = '0;
          y_nxt      = '0;
          target_nxt = '0;
          state_nxt  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (handshake) begin
          // The final pixel leaves the counters parked on the last coordinate.
          if ((x == X_LAST) && (y == Y_LAST)) begin
            state_nxt = ST_DONE;
          end else begin
            if (x == X_LAST) begin
              x_nxt = '0;
              y_nxt = y + 1'b1;
            end else begin
              x_nxt = x + 1'b1;
            end
            target_nxt = (target == n_last) ? 2'd0 : target + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    job.job_valid = 4'b0000;
    job.job_x     = '0;
    job.job_y     = '0;
    job.job_first = 1'b0;
    job.job_eol   = 1'b0;
    if (state == ST_DISPATCH) begin
      job.job_valid = 4'b0001 << target;
      job.job_x     = x;
      job.job_y     = y;
      job.job_first = (x == '0) && (y == '0);
      job.job_eol   = (x == X_LAST);
    end
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher on a 4x2 frame: round-robin order,
// back-pressure, core-count clamping, mid-frame reset and continuous start.
module tb_pixel_dispatcher;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int XW  = 10;
  localparam int YW  = 10;

  logic       aclk;
  logic       areset;
  logic       start;
  logic [2:0] no_of_extra_cores;
  logic       busy;
  logic       frame_done;
  logic [1:0] dbg_state;

  int tests_run;
  int tests_failed;

  pixel_job_if #(.X_W(XW), .Y_W(YW)) job_bus ();

  pixel_dispatcher #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .X_W          (XW),
    .Y_W          (YW)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .start            (start),
    .no_of_extra_cores(no_of_extra_cores),
    .job              (job_bus),
    .busy             (busy),
    .frame_done       (frame_done),
    .dbg_state        (dbg_state)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic launch(input logic [2:0] extra);
    no_of_extra_cores = extra;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    start = 1'b0;
    no_of_extra_cores = 3'd0;
    job_bus.core_ready = 4'b0000;
    tick();
    tick();
    areset = 1'b0;
    tests_run++;
    if (job_bus.job_valid !== 4'b0000 || busy !== 1'b0 || frame_done !== 1'b0 ||
        job_bus.job_x !== 10'd0 || job_bus.job_y !== 10'd0 ||
        job_bus.job_first !== 1'b0 || job_bus.job_eol !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b x=%0d y=%0d first=%b eol=%b st=%0d, required all 0",
               job_bus.job_valid, busy, frame_done, job_bus.job_x, job_bus.job_y,
               job_bus.job_first, job_bus.job_eol, dbg_state);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || job_bus.job_valid !== 4'b0000) begin
      $display("FAIL idle_no_start: got busy=%b valid=%b, required 0/0000", busy, job_bus.job_valid);
      tests_failed++;
    end
  endtask

  // Checks one frame of W*H jobs from job index k0; n = active core count.
  task automatic run_frame(input string name, input int k0, input int n);
    logic [3:0] exp_v;
    for (int k = k0; k < W*H; k++) begin
      exp_v = 4'b0001 << (k % n);
      tests_run++;
      if (job_bus.job_valid !== exp_v || job_bus.job_x !== 10'(k % W) ||
          job_bus.job_y !== 10'(k / W) || job_bus.job_first !== (k == 0) ||
          job_bus.job_eol !== ((k % W) == W-1) || busy !== 1'b1) begin
        $display("FAIL %s job%0d: got valid=%b x=%0d y=%0d first=%b eol=%b busy=%b, required valid=%b x=%0d y=%0d first=%b eol=%b busy=1",
                 name, k, job_bus.job_valid, job_bus.job_x, job_bus.job_y, job_bus.job_first,
                 job_bus.job_eol, busy, exp_v, k % W, k / W, k == 0, (k % W) == W-1);
        tests_failed++;
      end
      tick();
    end
    tests_run++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || job_bus.job_valid !== 4'b0000) begin
      $display("FAIL %s done_cycle: got done=%b busy=%b valid=%b, required 1/1/0000",
               name, frame_done, busy, job_bus.job_valid);
      tests_failed++;
    end
    tick();
  endtask

  task automatic check_idle(input string name);
    tests_run++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || job_bus.job_valid !== 4'b0000 || dbg_state !== 2'd0) begin
      $display("FAIL %s idle_after: got done=%b busy=%b valid=%b st=%0d, required 0/0/0000/0",
               name, frame_done, busy, job_bus.job_valid, dbg_state);
      tests_failed++;
    end
  endtask

  task automatic test_single_core();
    job_bus.core_ready = 4'b0001;
    launch(3'd0);
    run_frame("single", 0, 1);
    check_idle("single");
  endtask

  task automatic test_four_cores();
    job_bus.core_ready = 4'b1111;
    launch(3'd3);
    run_frame("four", 0, 4);
    check_idle("four");
  endtask

  task automatic test_back_pressure();
    job_bus.core_ready = 4'b0001;
    launch(3'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (job_bus.job_valid !== 4'b0010 || job_bus.job_x !== 10'd1 || job_bus.job_y !== 10'd0) begin
        $display("FAIL bp_hold%0d: got valid=%b x=%0d y=%0d, required 0010 x=1 y=0",
                 i, job_bus.job_valid, job_bus.job_x, job_bus.job_y);
        tests_failed++;
      end
      if (i == 5) job_bus.core_ready = 4'b0011;
      tick();
    end
    run_frame("bp", 2, 2);
    check_idle("bp");
  endtask

  task automatic test_clamp();
    job_bus.core_ready = 4'b1111;
    launch(3'd7);
    no_of_extra_cores = 3'd0;
    run_frame("clamp", 0, 4);
    check_idle("clamp");
  endtask

  task automatic test_reset_mid();
    job_bus.core_ready = 4'b1111;
    launch(3'd3);
    tick();
    tick();
    tick();
    tests_run++;
    if (job_bus.job_valid !== 4'b1000 || job_bus.job_x !== 10'd3) begin
      $display("FAIL rst_mid_pre: got valid=%b x=%0d, required 1000 x=3", job_bus.job_valid, job_bus.job_x);
      tests_failed++;
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tests_run++;
    if (job_bus.job_valid !== 4'b0000 || busy !== 1'b0 || frame_done !== 1'b0 ||
        job_bus.job_x !== 10'd0 || job_bus.job_eol !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL rst_mid_outputs: got valid=%b busy=%b done=%b x=%0d eol=%b st=%0d, required all 0",
               job_bus.job_valid, busy, frame_done, job_bus.job_x, job_bus.job_eol, dbg_state);
      tests_failed++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (frame_done !== 1'b0) begin
        $display("FAIL rst_mid_no_done%0d: got done=%b, required 0", i, frame_done);
        tests_failed++;
      end
    end
    launch(3'd3);
    run_frame("rst_restart", 0, 4);
    check_idle("rst_restart");
  endtask

  task automatic test_start_held();
    job_bus.core_ready = 4'b0001;
    no_of_extra_cores = 3'd0;
    start = 1'b1;
    tick();
    run_frame("held1", 0, 1);
    check_idle("held");
    tick();
    start = 1'b0;
    run_frame("held2", 0, 1);
    check_idle("held2");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    areset = 1'b1;
    start = 1'b0;
    no_of_extra_cores = 3'd0;
    job_bus.core_ready = 4'b0000;
    test_reset();
    test_single_core();
    test_four_cores();
    test_back_pressure();
    test_clamp();
    test_reset_mid();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
